mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the ODE solver's combinational `multiplier` (16-bit word: signed 13-bit mantissa in [15:3], 3-bit scale/fraction count in [2:0]) between NUM_REQ requesters, such as the solver's stage-evaluation units. It accepts one operand pair at a time with a valid/ready handshake and registers the operands into the shared multiplier. It returns the registered product, tagged with the requester index, under a valid/ready response handshake.

---
 rtl/ode_fixed_pkg.sv | 38 +++
 rtl/multiplier.sv | 75 +++++++
 rtl/rr_grant.sv | 51 +++++
 rtl/mult_arbiter.sv | 155 +++++++++++++++
 tb/tb_mult_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ode_fixed_pkg.sv
// ============================================================================
//  Package     : ode_fixed_pkg
//  Description : Shared word format, FSM state type and helpers for the ODE
//                solver fixed-point datapath (13-bit signed mantissa in
//                [15:3], 3-bit scale / fraction count in [2:0]).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ode_fixed_pkg;

   localparam int WORD_W    = 16;
   localparam int MANT_W    = 13;
   localparam int SCALE_W   = 3;

   // Full-precision product of two mantissas
   localparam int PROD_W    = 2 * MANT_W;
   // Width able to hold a shift of up to 2*MAX_SCALE
   localparam int SH_W      = SCALE_W + 1;
   localparam int MAX_SCALE = (1 << SCALE_W) - 1;
   // Bits of a product that must all equal the sign for it to fit a mantissa
   localparam int TOP_W     = PROD_W - MANT_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   // True when the top bits are a pure sign extension, i.e. the value fits
   // in a MANT_W-bit signed mantissa.
   function automatic logic fits_mant(input logic [TOP_W-1:0] top);
      return (&top) | (~|top);
   endfunction

endpackage : ode_fixed_pkg

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
//  Module      : multiplier
//  Description : Combinational fixed-point multiplier of the ODE solver.
//                Mantissas multiply, scales add; the product is shifted right
//                (arithmetic, truncating) until the scale is at most 7 and the
//                mantissa fits 13 bits. If the scale reaches 0 and it still
//                does not fit, the mantissa saturates.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier
   import ode_fixed_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] out
);

   logic signed [PROD_W-1:0] mant_a_ext;
   logic signed [PROD_W-1:0] mant_b_ext;
   logic signed [PROD_W-1:0] prod;
   logic        [SH_W-1:0]   scale_sum;
   logic        [SH_W-1:0]   scale_sh;
   logic        [SH_W-1:0]   fit_sh;
   logic        [SH_W-1:0]   need_sh;
   logic        [SH_W-1:0]   shift;
   logic        [TOP_W-1:0]  probe;
   logic                     fit_found;
   logic                     sat;
   logic        [MANT_W-1:0] mant_out;
   logic        [SCALE_W-1:0] scale_out;

   // Full-precision product and the smallest right shift that normalises it
   always_comb begin
      mant_a_ext = {{(PROD_W-MANT_W){a[WORD_W-1]}}, a[WORD_W-1:SCALE_W]};
      mant_b_ext = {{(PROD_W-MANT_W){b[WORD_W-1]}}, b[WORD_W-1:SCALE_W]};
      prod       = mant_a_ext * mant_b_ext;
      scale_sum  = {1'b0, a[SCALE_W-1:0]} + {1'b0, b[SCALE_W-1:0]};
      scale_sh   = (scale_sum > SH_W'(MAX_SCALE)) ? (scale_sum - SH_W'(MAX_SCALE)) : '0;

      // Smallest shift that brings the mantissa into 13-bit signed range;
      // a shift of MANT_W always fits, so that is the fallback.
      fit_sh    = SH_W'(MANT_W);
      fit_found = 1'b0;
      probe     = '0;
      for (int k = 0; k <= MANT_W; k++) begin
         probe = TOP_W'(prod >>> (k + MANT_W - 1));
         if (!fit_found && fits_mant(probe)) begin
            fit_sh    = SH_W'(k);
            fit_found = 1'b1;
         end
      end

      need_sh = (fit_sh > scale_sh) ? fit_sh : scale_sh;
      // Scale cannot drop below zero: clamp the shift and saturate instead
      sat     = (need_sh > scale_sum);
      shift   = sat ? scale_sum : need_sh;
   end

   // Assemble the output word
   always_comb begin
      scale_out = SCALE_W'(scale_sum - shift);
      if (sat) begin
         mant_out = prod[PROD_W-1] ? {1'b1, {(MANT_W-1){1'b0}}}
                                   : {1'b0, {(MANT_W-1){1'b1}}};
      end else begin
         mant_out = MANT_W'(prod >>> shift);
      end
      out = {mant_out, scale_out};
   end

endmodule : multiplier

`default_nettype wire

// File: rtl/rr_grant.sv
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin grant. Picks the lowest-index
//                request at or above rr_ptr, wrapping to the lowest-index
//                request below it when none is found.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_grant
);

   logic [NUM_REQ-1:0] upper_req;
   logic               upper_any;
   logic [NUM_REQ-1:0] scan_vec;

   // Split requests into the part at/above the pointer and pick the search set
   always_comb begin
      upper_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_req[i] = req[i] && (i >= int'(rr_ptr));
      end
      upper_any = |upper_req;
      scan_vec  = upper_any ? upper_req : req;
   end

   // Lowest set bit of the selected set becomes the one-hot grant
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_grant && scan_vec[i]) begin
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
            any_grant = 1'b1;
         end
      end
   end

endmodule : rr_grant

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
//  Module      : mult_arbiter
//  Description : Round-robin arbiter/sequencer sharing one combinational
//                multiplier between NUM_REQ requesters. One operand pair is
//                accepted in IDLE, multiplied in MUL, and the tagged product
//                is held in RESP until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter
   import ode_fixed_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [WORD_W*NUM_REQ-1:0] req_a,
   input  logic [WORD_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WORD_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      busy,
   output logic [15:0]               op_count
);

   state_t              state_q,     state_d;
   logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
   logic [ID_W-1:0]     id_q,        id_d;
   logic [WORD_W-1:0]   op_a_q,      op_a_d;
   logic [WORD_W-1:0]   op_b_q,      op_b_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]   rsp_data_q,  rsp_data_d;
   logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
   logic [15:0]         op_count_q,  op_count_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                any_grant;
   logic [WORD_W-1:0]   sel_a;
   logic [WORD_W-1:0]   sel_b;
   logic [ID_W-1:0]     ptr_after_grant;
   logic [WORD_W-1:0]   mul_out;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_grant (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   multiplier u_multiplier (
      .a   (op_a_q),
      .b   (op_b_q),
      .out (mul_out)
   );

   // Operand mux for the granted requester and the pointer value after it
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*WORD_W +: WORD_W];
            sel_b = req_b[i*WORD_W +: WORD_W];
         end
      end
      ptr_after_grant = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : (grant_idx + ID_W'(1));
   end

   // Next-state and datapath update for the IDLE -> MUL -> RESP sequence
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      op_count_d  = op_count_q;
      case (state_q)
         IDLE: begin
            // The grant is a subset of req_valid, so any_grant is the accept
            if (any_grant) begin
               op_a_d   = sel_a;
               op_b_d   = sel_b;
               id_d     = grant_idx;
               rr_ptr_d = ptr_after_grant;
               state_d  = MUL;
            end
         end
         MUL: begin
            rsp_data_d  = mul_out;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         op_count_q  <= op_count_d;
      end
   end

   // Grant is offered only in IDLE and never while reset is held
   assign req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_count_q;

endmodule : mult_arbiter

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Self-checking bench for mult_arbiter. Expected products are
//                queued when a grant is observed and compared when the
//                response handshake occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_REQ-1:0]   req_valid;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [15:0]          rsp_data;
   logic [ID_W-1:0]      rsp_id;
   logic                 busy;
   logic [15:0]          op_count;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [15:0]     data;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e_mon;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_cnt;

   logic [15:0] edge_a [4] = '{16'h7FF8, 16'h8000, 16'hFFFF, 16'h8007};
   logic [15:0] edge_b [4] = '{16'h7FF8, 16'h7FF8, 16'hFFFF, 16'h0017};

   mult_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference product: shift right one step at a time until the scale is
   // legal and the mantissa fits, saturating if the scale runs out.
   function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b);
      int ma, mb, p, s;
      ma = int'($signed(a[15:3]));
      mb = int'($signed(b[15:3]));
      s  = int'(a[2:0]) + int'(b[2:0]);
      p  = ma * mb;
      while (s > 0 && (s > 7 || p > 4095 || p < -4096)) begin
         p = p >>> 1;
         s = s - 1;
      end
      if (p > 4095)       p = 4095;
      else if (p < -4096) p = -4096;
      return {p[12:0], s[2:0]};
   endfunction

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
   endtask

   // Called at a falling edge with the DUT in IDLE and inputs already set.
   // Expects requester g to be granted, holds the response for 'hold' cycles.
   task automatic serve(input int g, input logic [15:0] exp_data, input int hold);
      exp_t e;
      #1;
      check_value("grant", 32'(req_ready), 32'(1) << g);
      check_value("idle_busy", 32'(busy), 32'd0);
      e.id   = ID_W'(g);
      e.data = exp_data;
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      rsp_ready    = (hold == 0);
      @(negedge clk);
      check_value("mul_ready", 32'(req_ready), 32'd0);
      check_value("mul_busy", 32'(busy), 32'd1);
      check_value("mul_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check_value("hold_valid", 32'(rsp_valid), 32'd1);
         check_value("hold_data", 32'(rsp_data), 32'(exp_data));
         check_value("hold_id", 32'(rsp_id), 32'(g));
         check_value("hold_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_value("rsp_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      check_value("op_count", 32'(op_count), 32'(exp_cnt));
      check_value("rsp_cleared", 32'(rsp_valid), 32'd0);
      check_value("back_idle", 32'(busy), 32'd0);
   endtask

   // Response side of the scoreboard: pop on every observed handshake
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         check_value("sb_depth", 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            e_mon = sb_q.pop_front();
            check_value("rsp_data", 32'(rsp_data), 32'(e_mon.data));
            check_value("rsp_id", 32'(rsp_id), 32'(e_mon.id));
         end
      end
   end

   initial begin
      logic [15:0] ra, rb;
      int          r;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      exp_cnt   = 16'd0;

      // Reset state, with requests pending while reset is held
      repeat (2) @(posedge clk);
      #1 req_valid = 4'b1111;
      @(negedge clk);
      check_value("rst_req_ready", 32'(req_ready), 32'd0);
      check_value("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_op_count", 32'(op_count), 32'd0);
      check_value("rst_rsp_data", 32'(rsp_data), 32'd0);
      check_value("rst_rsp_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      rst       = 1'b0;
      @(negedge clk);
      check_value("idle_no_req", 32'(req_ready), 32'd0);

      // All four requesters at once: served 0,1,2,3
      set_req(0, 16'hFF99, 16'h0020);
      set_req(1, 16'h00DA, 16'hFFE0);
      set_req(2, 16'h051D, 16'h058D);
      set_req(3, 16'h0039, 16'h02A4);
      req_valid = 4'b1111;
      serve(0, 16'hFE61, 0);
      serve(1, 16'hFCA2, 0);
      serve(2, 16'h70B7, 0);
      serve(3, 16'h1265, 0);

      // Single requester 0: 3.5 x 5.25
      set_req(0, 16'h0039, 16'h02A4);
      req_valid = 4'b0001;
      serve(0, 16'h1265, 0);

      // Fairness: serve 1, then 0 and 1 together -> 0 wins, then 1
      set_req(1, 16'h0100, 16'h0100);
      req_valid = 4'b0010;
      serve(1, mul_model(16'h0100, 16'h0100), 0);
      set_req(0, 16'h0123, 16'h0456);
      set_req(1, 16'hF00B, 16'h0031);
      req_valid = 4'b0011;
      serve(0, mul_model(16'h0123, 16'h0456), 0);
      serve(1, mul_model(16'hF00B, 16'h0031), 0);

      // Backpressure: requester 2 granted, 0 pending during a 5-cycle stall
      set_req(2, 16'h0A0A, 16'h0505);
      set_req(0, 16'hFF99, 16'h0020);
      req_valid = 4'b0101;
      serve(2, mul_model(16'h0A0A, 16'h0505), 5);
      serve(0, 16'hFE61, 0);

      // Normalisation and saturation corners
      for (int i = 0; i < 4; i++) begin
         set_req(i, edge_a[i], edge_b[i]);
         req_valid = NUM_REQ'(1) << i;
         serve(i, mul_model(edge_a[i], edge_b[i]), 0);
      end

      // Random operands from random single requesters
      for (int n = 0; n < 6; n++) begin
         r  = int'($urandom_range(0, NUM_REQ-1));
         ra = 16'($urandom);
         rb = 16'($urandom);
         set_req(r, ra, rb);
         req_valid = NUM_REQ'(1) << r;
         serve(r, mul_model(ra, rb), 0);
      end

      // Reset asserted while in MUL
      set_req(3, 16'h0039, 16'h02A4);
      req_valid = 4'b1000;
      #1 check_value("rm_grant", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      set_req(1, 16'h00DA, 16'hFFE0);
      req_valid = 4'b1010;
      @(negedge clk);
      check_value("rm_in_mul", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_value("rm_rsp_valid", 32'(rsp_valid), 32'd0);
      check_value("rm_busy", 32'(busy), 32'd0);
      check_value("rm_op_count", 32'(op_count), 32'd0);
      check_value("rm_req_ready", 32'(req_ready), 32'd0);
      exp_cnt = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      serve(1, 16'hFCA2, 0);

      // Reset asserted while in RESP
      set_req(3, 16'hFF99, 16'h0020);
      req_valid = 4'b1000;
      #1 check_value("rr_grant", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      #1 check_value("rr_in_resp", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      set_req(2, 16'h051D, 16'h058D);
      req_valid = 4'b1100;
      #1;
      check_value("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      check_value("rr_busy", 32'(busy), 32'd0);
      check_value("rr_op_count", 32'(op_count), 32'd0);
      check_value("rr_req_ready", 32'(req_ready), 32'd0);
      check_value("rr_rsp_data", 32'(rsp_data), 32'd0);
      exp_cnt = 16'd0;
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      serve(2, 16'h70B7, 0);
      serve(3, 16'hFE61, 0);

      // op_count wrap from 0xFFFF
      req_valid = '0;
      force dut.op_count_q = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1 release dut.op_count_q;
      @(negedge clk);
      check_value("wrap_pre", 32'(op_count), 32'hFFFF);
      exp_cnt = 16'hFFFF;
      set_req(1, 16'h0039, 16'h02A4);
      req_valid = 4'b0010;
      serve(1, 16'h1265, 0);

      @(negedge clk);
      check_value("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mult_arbiter

`default_nettype wire
